// File: rtl/mem_test_master.sv
// mem_test_master: initiator for the single-port valid/ready memory bus.
// One run writes expected(a) = a ^ PATTERN to every address 0..DEPTH-1,
// then reads every address back and compares. A per-state cycle guard
// aborts the run if the responder hangs in any handshake state.
//
// Ports:
//   clk            clock, rising edge
//   res            asynchronous active-low reset
//   start          run request, honoured only in IDLE or DONE
//   valid/wr_rd    request / direction (1 = write) to the responder
//   addr/wdata     transaction address and write data
//   rdata/ready    read data and responder acknowledge
//   busy/done      run in progress / run finished (held until next start)
//   pass           done with no mismatches and no timeout
//   timeout        run aborted by the handshake guard
//   err_count      number of mismatched reads
//   first_err_addr address of the first mismatch (0 if none)
module mem_test_master #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(8'hA5),
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]         CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_d, fea_d;
  logic [ADDR_WIDTH:0]   err_d;
  logic [WIDTH-1:0]      wdata_d;
  logic                  valid_d, wr_rd_d, busy_d, done_d, pass_d, to_d;

  function automatic logic [WIDTH-1:0] expected(input logic [ADDR_WIDTH-1:0] a);
    return WIDTH'(a) ^ PATTERN;
  endfunction

  always_comb begin
    state_d = state;
    addr_d  = addr;
    err_d   = err_count;
    fea_d   = first_err_addr;
    busy_d  = busy;
    done_d  = done;
    pass_d  = pass;
    to_d    = timeout;
    cnt_d   = '0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          err_d   = '0;
          fea_d   = '0;
          to_d    = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = WR_REQ;
        end
      end
      WR_REQ: if (ready) state_d = WR_GAP;
      WR_GAP: begin
        if (!ready) begin
          if (addr == ADDR_LAST) begin
            addr_d  = '0;
            state_d = RD_REQ;
          end else begin
            addr_d  = addr + 1'b1;
            state_d = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (ready) begin
          if (rdata != expected(addr)) begin
            err_d = err_count + 1'b1;
            if (err_count == '0) fea_d = addr;
          end
          state_d = RD_GAP;
        end
      end
      RD_GAP: begin
        if (!ready) begin
          if (addr == ADDR_LAST) begin
            state_d = DONE;
          end else begin
            addr_d  = addr + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Guard counter runs only while a handshake state makes no progress;
    // any state change clears it. Expiry overrides the normal next state
    // and leaves addr on the failing address.
    if (state != IDLE && state != DONE && state_d == state) begin
      if (cnt == CNT_LAST) begin
        to_d    = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end

    if (state_d == DONE && state != DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      pass_d = (err_d == '0) && !to_d;
    end

    valid_d = (state_d == WR_REQ) || (state_d == RD_REQ);
    wr_rd_d = (state_d == WR_REQ) || (state_d == WR_GAP);
    wdata_d = (state_d == WR_REQ) ? expected(addr_d) : wdata;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state          <= IDLE;
      cnt            <= '0;
      valid          <= 1'b0;
      wr_rd          <= 1'b0;
      addr           <= '0;
      wdata          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      valid          <= valid_d;
      wr_rd          <= wr_rd_d;
      addr           <= addr_d;
      wdata          <= wdata_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      timeout        <= to_d;
      err_count      <= err_d;
      first_err_addr <= fea_d;
    end
  end

endmodule

// File: tb/tb_mem_test_master.sv
// Bench for mem_test_master: a latency-configurable memory responder,
// a transaction-level model of the expected run (transaction index k,
// gap flag, stall counter), and per-cycle comparison of every output.
module tb_mem_test_master;

  localparam int DEPTH = 32;
  localparam int TMO   = 16;

  logic       clk, res, start, start_main, start_noise, noise_en;
  logic       valid, wr_rd, ready, busy, done, pass, timeout;
  logic [4:0] addr, first_err_addr;
  logic [7:0] wdata, rdata;
  logic [5:0] err_count;

  int total = 0;
  int bad   = 0;

  mem_test_master #(
    .WIDTH(8), .DEPTH(DEPTH), .ADDR_WIDTH(5), .PATTERN(8'hA5), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .res(res), .start(start), .valid(valid), .wr_rd(wr_rd),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
    .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- responder ----------------
  logic [7:0]  mem [DEPTH];
  logic [31:0] corrupt;
  int          stall_addr;
  int unsigned lat_max;
  int unsigned wcnt, wtgt;

  initial wtgt = 0;

  always @(posedge clk or negedge res) begin
    if (!res) begin
      ready <= 1'b0;
      wcnt  <= 0;
    end else begin
      if (valid && wr_rd && ready) mem[addr] <= wdata;
      if (ready) ready <= 1'b0;
      else if (valid && !(wr_rd && int'(addr) == stall_addr)) begin
        if (wcnt >= wtgt) begin
          ready <= 1'b1;
          wcnt  <= 0;
          wtgt  <= $urandom_range(0, lat_max);
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  always_comb rdata = mem[addr] ^ (corrupt[addr] ? 8'h3C : 8'h00);

  // start pulses while a run is in progress must be ignored
  always @(posedge clk) begin
    #2;
    start_noise = noise_en && busy && ($urandom_range(0, 7) == 0);
  end
  assign start = start_main | start_noise;

  // ---------------- model + compare ----------------
  // k counts completed transactions: 0..DEPTH-1 writes, DEPTH..2*DEPTH-1 reads.
  bit m_busy, m_done, m_pass, m_to, m_gap;
  int m_k, m_stuck, m_err, m_first;

  always @(negedge clk) begin
    if (!res) begin
      chk("rst_valid", valid, 0);   chk("rst_wr_rd", wr_rd, 0);
      chk("rst_addr", addr, 0);     chk("rst_wdata", wdata, 0);
      chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);     chk("rst_timeout", timeout, 0);
      chk("rst_err", err_count, 0); chk("rst_first", first_err_addr, 0);
      m_busy = 0; m_done = 0; m_pass = 0; m_to = 0; m_gap = 0;
      m_k = 0; m_stuck = 0; m_err = 0; m_first = 0;
    end else begin
      chk("valid", valid, int'(m_busy && !m_gap));
      chk("wr_rd", wr_rd, int'(m_busy && m_k < DEPTH));
      chk("addr", addr, (m_k < 2*DEPTH) ? (m_k % DEPTH) : DEPTH-1);
      if (m_busy && !m_gap && m_k < DEPTH) chk("wdata", wdata, (m_k % DEPTH) ^ 8'hA5);
      chk("busy", busy, int'(m_busy));
      chk("done", done, int'(m_done));
      chk("pass", pass, int'(m_pass));
      chk("timeout", timeout, int'(m_to));
      chk("err_count", err_count, m_err);
      chk("first_err_addr", first_err_addr, m_first);
      // advance the model by what the next edge will sample
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_done = 0; m_pass = 0; m_to = 0; m_gap = 0;
          m_k = 0; m_stuck = 0; m_err = 0; m_first = 0;
        end
      end else if (!m_gap && ready) begin
        if (m_k >= DEPTH && corrupt[m_k-DEPTH]) begin
          if (m_err == 0) m_first = m_k - DEPTH;
          m_err++;
        end
        m_gap = 1; m_stuck = 0;
      end else if (m_gap && !ready) begin
        m_gap = 0; m_stuck = 0; m_k++;
        if (m_k == 2*DEPTH) begin
          m_busy = 0; m_done = 1; m_pass = (m_err == 0);
        end
      end else begin
        m_stuck++;
        if (m_stuck == TMO) begin
          m_busy = 0; m_done = 1; m_pass = 0; m_to = 1;
        end
      end
    end
  end

  // n = edges from the start-sampling edge until done is visible;
  // v5 = cycles with a write request to address 5 on the bus.
  task automatic run(output int n, output int v5);
    n = 0; v5 = 0;
    @(posedge clk); #2 start_main = 1'b1;
    @(posedge clk); #2 start_main = 1'b0;
    @(negedge clk);
    chk("start_clears_err", err_count, 0);
    chk("start_sets_busy", busy, 1);
    n = 1;
    forever begin
      @(negedge clk);
      if (valid && wr_rd && addr == 5'd5) v5++;
      if (done) break;
      n++;
      if (n >= 3000) begin
        chk("run_finishes", 0, 1);
        break;
      end
    end
  endtask

  int n, v5, exp_first, guard;

  initial begin
    res = 1'b0; start_main = 1'b0; noise_en = 1'b0;
    corrupt = '0; stall_addr = -1; lat_max = 0;

    // reset with random start activity
    repeat (6) begin
      @(posedge clk); #2 start_main = 1'($urandom);
    end
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #2 start_main = 1'b0; res = 1'b1;
    repeat (4) @(posedge clk);

    // clean run, ideal responder: 3 edges per transaction
    noise_en = 1'b1;
    run(n, v5);
    chk("clean_cycles", n, 6*DEPTH);
    chk("clean_done", done, 1);
    chk("clean_pass", pass, 1);
    chk("clean_err", err_count, 0);

    // corrupted reads at 7 and 20
    corrupt = 32'h0010_0080; lat_max = 3;
    run(n, v5);
    chk("corrupt_err", err_count, 2);
    chk("corrupt_first", first_err_addr, 7);
    chk("corrupt_pass", pass, 0);
    chk("corrupt_timeout", timeout, 0);

    // restart after a failing run
    corrupt = '0;
    run(n, v5);
    chk("rerun_pass", pass, 1);
    chk("rerun_err", err_count, 0);

    // responder hangs on the write to address 5
    stall_addr = 5; lat_max = 2;
    run(n, v5);
    chk("tmo_valid_cycles", v5, TMO);
    chk("tmo_timeout", timeout, 1);
    chk("tmo_done", done, 1);
    chk("tmo_pass", pass, 0);
    chk("tmo_addr", addr, 5);
    chk("tmo_valid", valid, 0);
    stall_addr = -1;

    // reset in the middle of the read of address 12
    @(posedge clk); #2 start_main = 1'b1;
    @(posedge clk); #2 start_main = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(busy && valid && !wr_rd && addr == 5'd12) && guard < 3000);
    chk("reach_read12", int'(guard < 3000), 1);
    @(posedge clk); #1 res = 1'b0;
    #1;
    chk("midrst_valid", valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", addr, 0);
    chk("midrst_wr_rd", wr_rd, 0);
    repeat (3) @(posedge clk);
    #2 res = 1'b1;
    repeat (2) @(posedge clk);
    run(n, v5);
    chk("post_rst_pass", pass, 1);

    // randomized runs
    repeat (3) begin
      corrupt = $urandom & $urandom & $urandom;
      lat_max = $urandom_range(0, 4);
      run(n, v5);
      exp_first = 0;
      for (int i = DEPTH-1; i >= 0; i--) if (corrupt[i]) exp_first = i;
      chk("rand_err", err_count, $countones(corrupt));
      chk("rand_first", first_err_addr, exp_first);
      chk("rand_pass", pass, int'(corrupt == 0));
      chk("rand_timeout", timeout, 0);
    end

    noise_en = 1'b0;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
